// File: rtl/vector_writeback_ctrl.sv
// rtl/vector_writeback_ctrl.sv - write-back stage feeding the ping-pong vector buffer x_n port
module vector_writeback_ctrl #(
    parameter int LENGTH      = 1024,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ITER_W      = 16,
    localparam int ADDR_W     = $clog2(LENGTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [ITER_W-1:0]                      iterations,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [PARALLELISM-1:0][ADDR_W-1:0]     in_addr,
    input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] in_data,
    input  logic                                   in_last,
    output logic                                   x_n_valid,
    output logic                                   x_n_write,
    output logic                                   x_n_rready,
    input  logic                                   x_n_ready,
    output logic [PARALLELISM-1:0][ADDR_W-1:0]     x_n_addr,
    output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] x_n_wdata,
    output logic                                   ping,
    output logic [ITER_W-1:0]                      iter_count,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int BEATS  = LENGTH / PARALLELISM;
    localparam int BCNT_W = $clog2(BEATS + 1) + 1;
    localparam logic [BCNT_W-1:0] BEATS_C = BCNT_W'(BEATS);
    localparam logic [ADDR_W:0]   LEN_C   = (ADDR_W+1)'(LENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SWAP,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                                 r_state;
    logic                                   r_skid_full;
    logic                                   r_skid_last;
    logic [PARALLELISM-1:0][ADDR_W-1:0]     r_skid_addr;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] r_skid_data;
    logic [BCNT_W-1:0]                      r_beat_cnt;
    logic [ITER_W-1:0]                      r_iterations;
    logic [ITER_W-1:0]                      r_iter_count;
    logic                                   r_ping;
    logic                                   r_busy;
    logic                                   r_done;
    logic                                   r_err;

    logic                                   w_hs;
    logic                                   w_in_ready;
    logic                                   w_accept;
    logic                                   w_oor;
    logic [PARALLELISM-1:0][ADDR_W-1:0]     w_addr_fixed;

    assign w_hs = r_skid_full && x_n_ready;
    // Once the iteration's last beat sits in the skid, nothing more is taken until the swap is done.
    assign w_in_ready = (r_state == S_WRITE) && (!r_skid_full || (w_hs && !r_skid_last));
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_oor        = 1'b0;
        w_addr_fixed = in_addr;
        for (int l = 0; l < PARALLELISM; l++) begin
            if ({1'b0, in_addr[l]} >= LEN_C) begin
                w_oor           = 1'b1;
                w_addr_fixed[l] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_skid_full  <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_addr  <= '0;
            r_skid_data  <= '0;
            r_beat_cnt   <= '0;
            r_iterations <= '0;
            r_iter_count <= '0;
            r_ping       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ping <= 1'b0;
            r_done <= 1'b0;

            if (w_accept) begin
                r_skid_full <= 1'b1;
                r_skid_last <= in_last;
                r_skid_addr <= w_addr_fixed;
                r_skid_data <= in_data;
                if (w_oor) begin
                    r_err <= 1'b1;
                end
            end else if (w_hs) begin
                r_skid_full <= 1'b0;
            end

            if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
                if (r_skid_last && (r_beat_cnt + BCNT_W'(1) != BEATS_C)) begin
                    r_err <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_iter_count <= '0;
                        r_beat_cnt   <= '0;
                        r_iterations <= iterations;
                        if (iterations == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_hs && r_skid_last) begin
                        r_state      <= S_SWAP;
                        r_ping       <= 1'b1;
                        r_iter_count <= r_iter_count + ITER_W'(1);
                    end
                end
                S_SWAP: begin
                    r_beat_cnt <= '0;
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_iter_count == r_iterations) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign x_n_valid  = r_skid_full;
    assign x_n_write  = r_skid_full;
    assign x_n_rready = 1'b0;
    assign x_n_addr   = r_skid_addr;
    assign x_n_wdata  = r_skid_data;
    assign ping       = r_ping;
    assign iter_count = r_iter_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_vector_writeback_ctrl.sv
// tb/tb_vector_writeback_ctrl.sv - scoreboard bench for vector_writeback_ctrl
module tb_vector_writeback_ctrl;

    localparam int LENGTH = 24;
    localparam int DW     = 16;
    localparam int P      = 4;
    localparam int IW     = 8;
    localparam int AW     = $clog2(LENGTH);
    localparam int BEATS  = LENGTH / P;

    typedef logic [P-1:0][AW-1:0] addr_t;
    typedef logic [P-1:0][DW-1:0] data_t;
    typedef struct packed {
        addr_t a;
        data_t d;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] iterations;
    logic          in_valid;
    logic          in_ready;
    addr_t         in_addr;
    data_t         in_data;
    logic          in_last;
    logic          x_n_valid;
    logic          x_n_write;
    logic          x_n_rready;
    logic          x_n_ready;
    addr_t         x_n_addr;
    data_t         x_n_wdata;
    logic          ping;
    logic [IW-1:0] iter_count;
    logic          busy;
    logic          done;
    logic          err;

    vector_writeback_ctrl #(
        .LENGTH(LENGTH), .DATA_WIDTH(DW), .PARALLELISM(P), .ITER_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iterations(iterations),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .in_last(in_last), .x_n_valid(x_n_valid), .x_n_write(x_n_write),
        .x_n_rready(x_n_rready), .x_n_ready(x_n_ready), .x_n_addr(x_n_addr),
        .x_n_wdata(x_n_wdata), .ping(ping), .iter_count(iter_count), .busy(busy),
        .done(done), .err(err)
    );

    wr_t   sb[$];
    int    total = 0;
    int    bad = 0;
    int    ping_cnt = 0;
    int    ping_base = 0;
    int    done_cnt = 0;
    int    wr_cnt = 0;
    int    ready_mode = 0;
    bit    prev_stall = 0;
    bit    prev_ping = 0;
    addr_t prev_a;
    data_t prev_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       x_n_ready = 1'($urandom_range(0, 1));
            2:       x_n_ready = 1'b0;
            default: x_n_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst_n) begin
            prev_stall = 0;
            prev_ping  = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(x_n_valid), 64'(1));
                check("hold_addr", 64'(x_n_addr), 64'(prev_a));
                check("hold_data", 64'(x_n_wdata), 64'(prev_d));
            end
            if (prev_ping)
                check("settle_idle", 64'({x_n_valid, in_ready}), 64'(0));
            if (!busy)
                check("ready_when_idle", 64'(in_ready), 64'(0));
            if (x_n_valid && x_n_ready) begin
                wr_cnt++;
                check("x_write", 64'(x_n_write), 64'(1));
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h expected none", x_n_addr);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(x_n_addr), 64'(e.a));
                    check("wr_data", 64'(x_n_wdata), 64'(e.d));
                end
            end
            if (ping) begin
                ping_cnt++;
                check("iter_at_ping", 64'(iter_count), 64'(ping_cnt - ping_base));
            end
            if (done)
                done_cnt++;
            prev_stall = x_n_valid && !x_n_ready;
            prev_a     = x_n_addr;
            prev_d     = x_n_wdata;
            prev_ping  = ping;
        end
    end

    task automatic send_beat(input addr_t a, input data_t d, input bit last, input addr_t ea);
        int n = 0;
        wr_t e;
        in_addr  = a;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.a = ea;
                e.d = d;
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL beat_timeout: got no in_ready expected accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_run(input int iters, input int short_it, input int oor_it,
                          input bit dbl_start, input bit data_is_addr, input int rmode);
        bit    exp_err = 0;
        int    exp_wr = 0;
        int    p0, d0, w0, nb, n;
        addr_t a, ea;
        data_t d;
        ready_mode = rmode;
        ping_base  = ping_cnt;
        p0 = ping_cnt;
        d0 = done_cnt;
        w0 = wr_cnt;
        iterations = IW'(iters);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'(1));
        check("err_clear_on_start", 64'(err), 64'(0));
        @(posedge clk);
        #1;
        for (int it = 0; it < iters; it++) begin
            nb = (it == short_it) ? BEATS - 1 : BEATS;
            if (nb != BEATS) exp_err = 1;
            exp_wr += nb;
            for (int b = 0; b < nb; b++) begin
                for (int l = 0; l < P; l++) begin
                    a[l]  = AW'(b * P + l);
                    ea[l] = AW'(b * P + l);
                    d[l]  = data_is_addr ? DW'(b * P + l) : DW'($urandom);
                    if (it == oor_it && b == 1 && l == 2) begin
                        a[l]    = AW'(LENGTH + 2);
                        ea[l]   = '0;
                        exp_err = 1;
                    end
                end
                if (dbl_start && it == 0 && b == 1) begin
                    iterations = IW'(iters + 3);
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    iterations = IW'(iters);
                end
                send_beat(a, d, b == nb - 1, ea);
            end
        end
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'(1));
        if (iters == 0)
            check("zero_iter_latency_ok", 64'(n <= 2), 64'(1));
        check("ping_count", 64'(ping_cnt - p0), 64'(iters));
        check("iter_count_end", 64'(iter_count), 64'(iters));
        check("err_end", 64'(err), 64'(exp_err));
        check("write_count", 64'(wr_cnt - w0), 64'(exp_wr));
        check("sb_empty", 64'(sb.size()), 64'(0));
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'(0));
        check("done_one_cycle", 64'(done), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_run();
        int    p0;
        addr_t a;
        data_t d;
        ready_mode = 2;
        p0 = ping_cnt;
        iterations = IW'(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int l = 0; l < P; l++) begin
            a[l] = AW'(l);
            d[l] = DW'($urandom);
        end
        send_beat(a, d, 1'b0, a);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_valid", 64'(x_n_valid), 64'(1));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_xvalid", 64'(x_n_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_iter", 64'(iter_count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_no_ping", 64'(ping_cnt - p0), 64'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        iterations = '0;
        in_valid = 1'b0;
        in_addr = '0;
        in_data = '0;
        in_last = 1'b0;
        x_n_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready0", 64'(in_ready), 64'(0));
        check("rst_outputs0", 64'({ping, done, busy, err}), 64'(0));
        check("rst_iter0", 64'(iter_count), 64'(0));
        check("rst_xn0", 64'({x_n_valid, x_n_write, x_n_rready}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_run(1, -1, -1, 1'b0, 1'b1, 0);
        do_run(3, -1, -1, 1'b0, 1'b0, 1);
        do_run(2, 0, -1, 1'b1, 1'b0, 1);
        do_run(1, -1, 0, 1'b0, 1'b0, 0);
        do_run(0, -1, -1, 1'b0, 1'b0, 0);
        reset_mid_run();
        do_run(2, -1, -1, 1'b0, 1'b0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
